// File: rtl/matmul2x2_sequencer.sv
// matmul2x2_sequencer: collects two 2x2 operand matrices from a byte stream,
// computes C = A x B with one time-shared multiply-accumulate unit over eight
// cycles, and returns the four result elements over a valid/ready handshake.
module matmul2x2_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [1:0]        res_idx,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [2:0]          load_cnt_r;
  logic [2:0]          mac_cnt_r;
  logic [1:0]          idx_r;
  logic                done_r;
  logic [DATA_W-1:0]   a_r [4];
  logic [DATA_W-1:0]   b_r [4];
  logic [ACC_W-1:0]    acc_r;
  logic [ACC_W-1:0]    c_r [4];

  logic                load_fire_s;
  logic                res_fire_s;
  logic                last_res_s;
  logic [1:0]          mul_a_idx_s;
  logic [1:0]          mul_b_idx_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [ACC_W-1:0]    prod_ext_s;

  // Handshake qualifiers; abort suppresses any transfer in the same cycle.
  assign load_fire_s = (state_r == ST_LOAD) & in_valid & ~abort;
  assign res_fire_s  = (state_r == ST_OUTPUT) & res_ready & ~abort;
  assign last_res_s  = res_fire_s & (idx_r == 2'd3);

  // MAC step m: element k = m[2:1] gives row i = m[2], col j = m[1];
  // phase p = m[0] selects the inner-product term A[i][p] * B[p][j].
  assign mul_a_idx_s = {mac_cnt_r[2], mac_cnt_r[0]};
  assign mul_b_idx_s = {mac_cnt_r[0], mac_cnt_r[1]};
  assign prod_s      = {{DATA_W{1'b0}}, a_r[mul_a_idx_s]} * {{DATA_W{1'b0}}, b_r[mul_b_idx_s]};
  assign prod_ext_s  = {{(ACC_W-2*DATA_W){1'b0}}, prod_s};

  assign res_data = c_r[idx_r];
  assign res_idx  = idx_r;
  assign done     = done_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort always returns to LOAD.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (load_fire_s && (load_cnt_r == 3'd7)) begin
            state_s = ST_COMPUTE;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_COMPUTE: begin
          if (mac_cnt_r == 3'd7) begin
            state_s = ST_OUTPUT;
          end else begin
            state_s = ST_COMPUTE;
          end
        end
        ST_OUTPUT: begin
          if (last_res_s) begin
            state_s = ST_LOAD;
          end else begin
            state_s = ST_OUTPUT;
          end
        end
        default: state_s = ST_LOAD;
      endcase
    end
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_LOAD: begin
        in_ready = 1'b1;
      end
      ST_COMPUTE: begin
        busy = 1'b1;
      end
      ST_OUTPUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Operand capture: A00..A11 then B00..B11; counter wraps to 0 after B11.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_r <= 3'd0;
      for (int n = 0; n < 4; n++) begin
        a_r[n] <= '0;
        b_r[n] <= '0;
      end
    end else if (abort) begin
      load_cnt_r <= 3'd0;
    end else if (load_fire_s) begin
      if (load_cnt_r[2]) begin
        b_r[load_cnt_r[1:0]] <= in_data;
      end else begin
        a_r[load_cnt_r[1:0]] <= in_data;
      end
      load_cnt_r <= load_cnt_r + 3'd1;
    end else begin
      load_cnt_r <= load_cnt_r;
    end
  end

  // Multiply-accumulate sequence: even steps seed acc, odd steps write C[k].
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      mac_cnt_r <= 3'd0;
      acc_r     <= '0;
      for (int n = 0; n < 4; n++) begin
        c_r[n] <= '0;
      end
    end else if (state_r == ST_COMPUTE) begin
      mac_cnt_r <= mac_cnt_r + 3'd1;
      if (mac_cnt_r[0]) begin
        c_r[mac_cnt_r[2:1]] <= acc_r + prod_ext_s;
      end else begin
        acc_r <= prod_ext_s;
      end
    end else begin
      mac_cnt_r <= mac_cnt_r;
    end
  end

  // Result index advance and one-cycle completion pulse after C11 is taken.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      idx_r  <= 2'd0;
      done_r <= 1'b0;
    end else begin
      done_r <= last_res_s;
      if (res_fire_s) begin
        idx_r <= idx_r + 2'd1;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

endmodule

// File: tb/tb_matmul2x2_sequencer.sv
// Self-checking bench for matmul2x2_sequencer: directed scenarios plus random
// operands, checked against a plain matrix-multiply reference model.
module tb_matmul2x2_sequencer;

  localparam int DW = 8;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] res_data;
  logic [1:0]    res_idx;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int first_acc = 0;
  int last_acc  = 0;

  matmul2x2_sequencer #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Edge counter and done-pulse counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: C[i][j] = sum_p A[i][p] * B[p][j], row-major flattening.
  function automatic logic [3:0][31:0] matmul(input logic [3:0][7:0] a, input logic [3:0][7:0] b);
    logic [3:0][31:0] r;
    for (int row = 0; row < 2; row++)
      for (int col = 0; col < 2; col++)
        r[2*row+col] = 32'(int'(a[2*row]) * int'(b[col]) + int'(a[2*row+1]) * int'(b[2+col]));
    return r;
  endfunction

  task automatic load_ops(input logic [3:0][7:0] a, input logic [3:0][7:0] b, input int n, input bit gaps);
    int k = 0;
    int spins = 0;
    while (k < n && spins < 400) begin
      @(negedge clk);
      spins++;
      if (gaps && $urandom_range(0, 99) < 35) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = (k < 4) ? a[k] : b[k-4];
        if (in_ready === 1'b1) begin
          if (k == 0) first_acc = cyc + 1;
          k++;
        end
      end
    end
    check("load_count", k, n);
  endtask

  task automatic compute_wait();
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      check("compute_res_valid", res_valid, 1'b0);
      check("compute_busy", busy, 1'b1);
      check("compute_in_ready", in_ready, 1'b0);
    end
  endtask

  task automatic collect(input logic [3:0][31:0] exp, input int stall_idx, input int stall_n);
    int cnt = 0;
    int st = 0;
    int spins = 0;
    while (cnt < 4 && spins < 60) begin
      @(negedge clk);
      spins++;
      in_valid = 1'b0;
      check("res_valid", res_valid, 1'b1);
      check("res_idx", res_idx, cnt);
      check("res_data", res_data, exp[cnt]);
      check("done_low_output", done, 1'b0);
      if (cnt == stall_idx && st < stall_n) begin
        res_ready = 1'b0;
        st++;
      end else begin
        res_ready = 1'b1;
        if (res_valid === 1'b1) begin
          cnt++;
          if (cnt == 4) last_acc = cyc + 1;
        end
      end
    end
    check("collect_count", cnt, 4);
  endtask

  task automatic finish_product();
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("in_ready_after", in_ready, 1'b1);
    check("res_valid_after", res_valid, 1'b0);
    check("busy_after", busy, 1'b0);
    check("res_idx_after", res_idx, 2'd0);
    @(negedge clk);
    check("done_single", done, 1'b0);
  endtask

  task automatic run_product(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                             input bit gaps, input int stall_idx, input int stall_n);
    logic [3:0][31:0] exp;
    exp = matmul(a, b);
    load_ops(a, b, 8, gaps);
    compute_wait();
    collect(exp, stall_idx, stall_n);
    finish_product();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_res_idx"}, res_idx, 2'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
  endtask

  initial begin
    logic [3:0][7:0] a_basic;
    logic [3:0][7:0] b_basic;
    logic [3:0][7:0] a_max;
    logic [3:0][7:0] a_id;
    logic [3:0][7:0] b_ab;
    logic [3:0][7:0] ra;
    logic [3:0][7:0] rb;
    logic [3:0][7:0] ra2;
    logic [3:0][7:0] rb2;
    logic [3:0][31:0] exp;
    int d0;
    int l1;
    int f1;

    a_basic = {8'd4, 8'd3, 8'd2, 8'd1};
    b_basic = {8'd8, 8'd7, 8'd6, 8'd5};
    a_max   = {8'd255, 8'd255, 8'd255, 8'd255};
    a_id    = {8'd1, 8'd0, 8'd0, 8'd1};
    b_ab    = {8'd6, 8'd7, 8'd8, 8'd9};

    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = 8'd0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic product, spot-check model constants too.
    exp = matmul(a_basic, b_basic);
    check("model_c00", exp[0], 32'd19);
    check("model_c11", exp[3], 32'd50);
    d0 = done_cnt;
    run_product(a_basic, b_basic, 1'b0, 9, 0);
    check("basic_done_count", done_cnt, d0 + 1);

    // Maximum values: every element 130050.
    run_product(a_max, a_max, 1'b0, 9, 0);

    // Gaps during load, 5-cycle stall at index 1.
    run_product(a_basic, b_basic, 1'b1, 1, 5);
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 4; n++) begin
        ra[n] = 8'($urandom_range(0, 255));
        rb[n] = 8'($urandom_range(0, 255));
      end
      run_product(ra, rb, 1'b1, r, 2 + r);
    end

    // Abort at COMPUTE step m=3.
    d0 = done_cnt;
    load_ops(a_basic, b_basic, 8, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (n == 4) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_res_valid", res_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
      check("abort_stays_load", in_ready, 1'b1);
    end
    check("abort_done_count", done_cnt, d0);
    run_product(a_id, b_ab, 1'b0, 9, 0);

    // Reset after 5 operands accepted.
    for (int n = 0; n < 4; n++) begin
      ra[n] = 8'($urandom_range(0, 255));
      rb[n] = 8'($urandom_range(0, 255));
    end
    load_ops(a_max, a_max, 5, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midload_reset");
    run_product(ra, rb, 1'b0, 9, 0);

    // Back-to-back products with res_ready held high.
    for (int n = 0; n < 4; n++) begin
      ra[n]  = 8'($urandom_range(0, 255));
      rb[n]  = 8'($urandom_range(0, 255));
      ra2[n] = 8'($urandom_range(0, 255));
      rb2[n] = 8'($urandom_range(0, 255));
    end
    d0 = done_cnt;
    load_ops(ra, rb, 8, 1'b0);
    f1 = first_acc;
    compute_wait();
    collect(matmul(ra, rb), 9, 0);
    l1 = last_acc;
    load_ops(ra2, rb2, 8, 1'b0);
    check("b2b_next_a00", first_acc, l1 + 1);
    compute_wait();
    collect(matmul(ra2, rb2), 9, 0);
    check("b2b_total_cycles", last_acc - f1 + 1, 40);
    finish_product();
    check("b2b_done_count", done_cnt, d0 + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
